joy_db15_cond: RTL and testbench
================================

# joy_db15_cond

Conditioning stage between the DB15 splitter reader and the core's player inputs. It takes the two 16-bit active-high DB15 joystick words and filters each used bit with a tick-based debouncer. It flags a port as invalid when its data line is stuck low, then ORs the result with the HPS/USB joystick words to drive the core's `joystick_0`/`joystick_1`. Player swap is applied here, so the splitter reader stays a pure shifter.

## Interface
Parameters:
- `SAMPLE_DIV`, 48000: `clk` cycles per sample tick (1 kHz at 48 MHz).
- `DEBOUNCE_N`, 4: consecutive ticks a bit must disagree with its filtered value before the filtered value flips.
- `STUCK_N`, 16: consecutive ticks a raw word must have bits 11:0 all set before that port is declared invalid.
- `AF_HALF`, 33: autofire half-period in ticks (autofire build only).

Ports (one clock `clk`, synchronous active-high reset `reset`):
- `clk`  in  1  system clock, 48–50 MHz.
- `reset`  in  1  synchronous, active-high.
- `db15_en`  in  1  OSD enable for the DB15 path.
- `swap`  in  1  1 = DB15 port 1 feeds player 2, and port 2 feeds player 1.
- `joy_db15_1`  in  16  splitter port 1 word, active-high, layout `11:LS 10:ST 9..4:F..A 3:U 2:D 1:L 0:R`.
- `joy_db15_2`  in  16  splitter port 2 word, same layout.
- `joy_usb_1`  in  16  HPS joystick, player 1.
- `joy_usb_2`  in  16  HPS joystick, player 2.
- `joystick_0`  out  16  merged player 1.
- `joystick_1`  out  16  merged player 2.
- `db15_valid`  out  2  per-port valid flag; bit 0 = port 1.

## Operation
- **Input sync:** both DB15 words pass through 2-flop synchronisers, because they are generated on a derived `JOY_CLK` and may tear mid-frame. Bits 15:12 are discarded and treated as 0.
- **Prescaler:** counts 0..`SAMPLE_DIV`-1 and emits a 1-cycle `tick` on wrap.
- **Debounce, per bit (24 instances):**
  - On `tick`, if raw ≠ filtered, a saturating counter increments; if raw = filtered, the counter clears.
  - When the counter reaches `DEBOUNCE_N`, the filtered bit takes the raw value and the counter clears.
  - A glitch shorter than `DEBOUNCE_N` ticks never reaches the output.
- **Stuck detection, per port:**
  - On `tick`, if raw[11:0] = 12'hFFF, the stuck counter increments, saturating at `STUCK_N`; otherwise it clears.
  - `db15_valid[p]` = (stuck counter < `STUCK_N`).
  - Recovery takes one tick after a non-FFF word arrives.
- **Merge, registered:**
  - `joystick_0` = `joy_usb_1` | (`db15_en` & valid(src) ? {4'b0, filt(src)} : 0).
  - src = port 1 if `swap` = 0, else port 2. Player 2 is symmetric.
- Debouncers and stuck counters run regardless of `db15_en` and `swap`. Toggling either input does not disturb filter state.

## Timing
- **Reset:** on the next edge, `joystick_0` = `joystick_1` = 0, `db15_valid` = 2'b11, and all counters, filtered bits and synchronisers = 0.
- **USB path:** 1 cycle, `joy_usb_*` → `joystick_*`.
- **DB15 path:**
  - Press to output: 2 sync cycles, then `DEBOUNCE_N` ticks, then 1 output register cycle.
  - Total is between (`DEBOUNCE_N`-1)·`SAMPLE_DIV`+3 and `DEBOUNCE_N`·`SAMPLE_DIV`+3 cycles.
- **`swap` / `db15_en` changes:** visible on the output 1 cycle later.
- **Simultaneous events:**
  - A tick and a raw change in the same cycle: the tick samples the already-synchronised value only.
  - USB and DB15 pressing the same bit: the output is 1.
  - Reset asserted mid-debounce: the count is lost and the bit restarts from 0.
- **Counter widths:** $clog2(param+1). Counters saturate and never wrap.

## Configuration
- **`JOY_DB15_COND_AUTOFIRE_EN` defined:**
  - While filtered button B (bit 5) is held, output bit 4 (A) of that DB15 source is forced to a square wave of `AF_HALF` ticks high, then `AF_HALF` low, ORed with the real A.
  - The phase counter resets to the high phase when B is released.
  - USB words are not affected.
- **Not defined:** bit 5 passes through unchanged, and no autofire logic is synthesised.

## Structure
- **Package `joy_pkg`:**
  - Bit-index constants `JOY_R`=0, `JOY_L`=1, `JOY_D`=2, `JOY_U`=3, `JOY_A`..`JOY_F`=4..9, `JOY_START`=10, `JOY_SELECT`=11.
  - `JOY_USED_MASK` = 12'hFFF.
  - typedef `joy_word_t` = logic [15:0].
- **Sub-module `joy_debounce`:** single-bit filter with inputs `clk`, `reset`, `tick`, `din` and output `dout`, parameterised by `DEBOUNCE_N`. Instantiated per used bit.
- Top level holds the prescaler, synchronisers, stuck counters, merge/swap registers and the optional autofire.

## Test plan
Bench uses `SAMPLE_DIV`=4, `DEBOUNCE_N`=4, `STUCK_N`=8, `AF_HALF`=2.
- **Debounce pass:** `joy_db15_1`=16'h0010 held 20 cycles → `joystick_0`=16'h0010 within 4·4+3 cycles; release → 0 after the same latency.
- **Glitch reject:** bit 0 pulsed for 2 ticks (8 cycles) → `joystick_0` stays 0.
- **Stuck port:** `joy_db15_2`=16'hFFFF for 40 cycles → `db15_valid`=2'b01 and `joystick_1`=0; then 16'h0000 → `db15_valid`=2'b11 within 1 tick.
- **Merge and swap:**
  - `joy_usb_1`=16'h0400 and port 2 holding 16'h0001 with `swap`=1 → `joystick_0`=16'h0401 once debounced.
  - `db15_en`=0 → `joystick_0`=16'h0400 the next cycle.
- **Reset mid-op:** reset pulsed while bit 3 is 2 ticks into its debounce → outputs 0 the next cycle; bit 3 needs a full 4 ticks after reset.
- **Autofire (macro defined):** hold 16'h0020 → bit 4 of `joystick_0` toggles every 8 cycles while bit 5 stays 1.

Source files
------------

// File: rtl/joy_pkg.sv
// Shared constants and types for the DB15 joystick conditioning path.
// Bit layout: 11:LS 10:ST 9..4:F..A 3:U 2:D 1:L 0:R.
package joy_pkg;

   localparam int JOY_R      = 0;
   localparam int JOY_L      = 1;
   localparam int JOY_D      = 2;
   localparam int JOY_U      = 3;
   localparam int JOY_A      = 4;
   localparam int JOY_B      = 5;
   localparam int JOY_C      = 6;
   localparam int JOY_D_BTN  = 7;
   localparam int JOY_E      = 8;
   localparam int JOY_F      = 9;
   localparam int JOY_START  = 10;
   localparam int JOY_SELECT = 11;

   localparam logic [11:0] JOY_USED_MASK = 12'hFFF;

   typedef logic [15:0] joy_word_t;

   localparam joy_word_t JOY_WORD_MASK = {4'b0000, JOY_USED_MASK};

   function automatic joy_word_t joy_widen(input logic [11:0] bits);
      return {4'b0000, bits};
   endfunction

endpackage

// File: rtl/joy_debounce.sv
// Single-bit tick-based debouncer: the output follows the input only after
// DEBOUNCE_N consecutive disagreeing ticks.
module joy_debounce
   import joy_pkg::*;
#(
   parameter int DEBOUNCE_N = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic tick,
   input  logic din,
   output logic dout
);

   localparam int CW = $clog2(DEBOUNCE_N + 1);

   logic [CW-1:0] r_cnt;
   logic          r_dout;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt  <= '0;
         r_dout <= 1'b0;
      end else if (tick) begin
         if (din != r_dout) begin
            if (r_cnt == CW'(DEBOUNCE_N - 1)) begin
               r_dout <= din;
               r_cnt  <= '0;
            end else begin
               r_cnt <= r_cnt + 1'b1;
            end
         end else begin
            r_cnt <= '0;
         end
      end
   end

   assign dout = r_dout;

endmodule

// File: rtl/joy_db15_cond.sv
// DB15 joystick conditioning: sync, debounce, stuck-low detect, swap, USB merge.
// Optional autofire on button B when JOY_DB15_COND_AUTOFIRE_EN is defined.
module joy_db15_cond
   import joy_pkg::*;
#(
   parameter int SAMPLE_DIV = 48000,
   parameter int DEBOUNCE_N = 4,
   parameter int STUCK_N    = 16,
   parameter int AF_HALF    = 33
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        db15_en,
   input  logic        swap,
   input  logic [15:0] joy_db15_1,
   input  logic [15:0] joy_db15_2,
   input  logic [15:0] joy_usb_1,
   input  logic [15:0] joy_usb_2,
   output logic [15:0] joystick_0,
   output logic [15:0] joystick_1,
   output logic [1:0]  db15_valid
);

   localparam int PW = $clog2(SAMPLE_DIV + 1);
   localparam int SW = $clog2(STUCK_N + 1);

   if (SAMPLE_DIV < 1 || DEBOUNCE_N < 1 || STUCK_N < 1 || AF_HALF < 1) begin : g_bad_param
      $error("joy_db15_cond: parameters must be >= 1");
   end

   joy_word_t   r_s1_1, r_s2_1, r_s1_2, r_s2_2;
   logic [PW-1:0] r_pre;
   logic        w_tick;
   logic [11:0] w_f1, w_f2;
   logic [11:0] w_p1, w_p2;
   logic [SW-1:0] r_st1, r_st2;
   logic [1:0]  w_valid;
   joy_word_t   r_j0, r_j1;
   logic [11:0] w_src0, w_src1;
   logic        w_v0, w_v1;

   // Upper nibble is masked on entry so it can never leak into the core.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_s1_1 <= '0;
         r_s2_1 <= '0;
         r_s1_2 <= '0;
         r_s2_2 <= '0;
      end else begin
         r_s1_1 <= joy_db15_1 & JOY_WORD_MASK;
         r_s2_1 <= r_s1_1;
         r_s1_2 <= joy_db15_2 & JOY_WORD_MASK;
         r_s2_2 <= r_s1_2;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_pre <= '0;
      end else if (w_tick) begin
         r_pre <= '0;
      end else begin
         r_pre <= r_pre + 1'b1;
      end
   end

   assign w_tick = (r_pre == PW'(SAMPLE_DIV - 1));

   for (genvar i = 0; i < 12; i++) begin : g_deb
      joy_debounce #(.DEBOUNCE_N(DEBOUNCE_N)) u_deb1 (
         .clk  (clk),
         .reset(reset),
         .tick (w_tick),
         .din  (r_s2_1[i]),
         .dout (w_f1[i])
      );
      joy_debounce #(.DEBOUNCE_N(DEBOUNCE_N)) u_deb2 (
         .clk  (clk),
         .reset(reset),
         .tick (w_tick),
         .din  (r_s2_2[i]),
         .dout (w_f2[i])
      );
   end

   // All-ones on the used bits means the open-collector data line is low.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_st1 <= '0;
         r_st2 <= '0;
      end else if (w_tick) begin
         if ((r_s2_1 & JOY_WORD_MASK) == JOY_WORD_MASK) begin
            if (r_st1 != SW'(STUCK_N)) r_st1 <= r_st1 + 1'b1;
         end else begin
            r_st1 <= '0;
         end
         if ((r_s2_2 & JOY_WORD_MASK) == JOY_WORD_MASK) begin
            if (r_st2 != SW'(STUCK_N)) r_st2 <= r_st2 + 1'b1;
         end else begin
            r_st2 <= '0;
         end
      end
   end

   assign w_valid[0] = (r_st1 < SW'(STUCK_N));
   assign w_valid[1] = (r_st2 < SW'(STUCK_N));

`ifdef JOY_DB15_COND_AUTOFIRE_EN
   localparam int AW = $clog2(2 * AF_HALF + 1);

   logic [AW-1:0] r_af1, r_af2;
   logic          w_af1_hi, w_af2_hi;

   // Phase restarts high whenever B is not held.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_af1 <= '0;
         r_af2 <= '0;
      end else begin
         if (!w_f1[JOY_B]) begin
            r_af1 <= '0;
         end else if (w_tick) begin
            r_af1 <= (r_af1 == AW'(2 * AF_HALF - 1)) ? '0 : r_af1 + 1'b1;
         end
         if (!w_f2[JOY_B]) begin
            r_af2 <= '0;
         end else if (w_tick) begin
            r_af2 <= (r_af2 == AW'(2 * AF_HALF - 1)) ? '0 : r_af2 + 1'b1;
         end
      end
   end

   assign w_af1_hi = (r_af1 < AW'(AF_HALF));
   assign w_af2_hi = (r_af2 < AW'(AF_HALF));

   always_comb begin
      w_p1        = w_f1;
      w_p2        = w_f2;
      w_p1[JOY_A] = w_f1[JOY_A] | (w_f1[JOY_B] & w_af1_hi);
      w_p2[JOY_A] = w_f2[JOY_A] | (w_f2[JOY_B] & w_af2_hi);
   end
`else
   assign w_p1 = w_f1;
   assign w_p2 = w_f2;
`endif

   assign w_src0 = swap ? w_p2 : w_p1;
   assign w_src1 = swap ? w_p1 : w_p2;
   assign w_v0   = swap ? w_valid[1] : w_valid[0];
   assign w_v1   = swap ? w_valid[0] : w_valid[1];

   always_ff @(posedge clk) begin
      if (reset) begin
         r_j0 <= '0;
         r_j1 <= '0;
      end else begin
         r_j0 <= joy_usb_1 | ((db15_en & w_v0) ? joy_widen(w_src0) : '0);
         r_j1 <= joy_usb_2 | ((db15_en & w_v1) ? joy_widen(w_src1) : '0);
      end
   end

   assign joystick_0 = r_j0;
   assign joystick_1 = r_j1;
   assign db15_valid = w_valid;

endmodule

// File: tb/tb_joy_db15_cond.sv
// Directed bench for joy_db15_cond with small tick/debounce parameters.
// Autofire steps run only when JOY_DB15_COND_AUTOFIRE_EN is defined.
module tb_joy_db15_cond;
   import joy_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        db15_en;
   logic        swap;
   logic [15:0] joy_db15_1, joy_db15_2, joy_usb_1, joy_usb_2;
   logic [15:0] joystick_0, joystick_1;
   logic [1:0]  db15_valid;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   joy_db15_cond #(
      .SAMPLE_DIV(4),
      .DEBOUNCE_N(4),
      .STUCK_N   (8),
      .AF_HALF   (2)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .db15_en   (db15_en),
      .swap      (swap),
      .joy_db15_1(joy_db15_1),
      .joy_db15_2(joy_db15_2),
      .joy_usb_1 (joy_usb_1),
      .joy_usb_2 (joy_usb_2),
      .joystick_0(joystick_0),
      .joystick_1(joystick_1),
      .db15_valid(db15_valid)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_rng(input string tag, input int n, input int lo, input int hi);
      total++;
      assert (n >= lo && n <= hi) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d..%0d", tag, n, lo, hi);
      end
   endtask

   // Returns edges waited until the output matches, or -1 on timeout.
   task automatic wait_j(input int which, input logic [15:0] exp, input int lim, output int n);
      logic [15:0] v;
      n = 0;
      while (n < lim) begin
         @(negedge clk);
         n++;
         v = (which == 0) ? joystick_0 : joystick_1;
         if (v === exp) return;
      end
      n = -1;
   endtask

   initial begin
      int n;
      int hits;
      reset      = 1'b1;
      db15_en    = 1'b1;
      swap       = 1'b0;
      joy_db15_1 = '0;
      joy_db15_2 = '0;
      joy_usb_1  = 16'hFFFF;
      joy_usb_2  = 16'hFFFF;
      repeat (3) @(negedge clk);
      check("rst_j0", joystick_0, 16'h0000);
      check("rst_j1", joystick_1, 16'h0000);
      check("rst_valid", db15_valid, 2'b11);

      reset     = 1'b0;
      joy_usb_1 = '0;
      joy_usb_2 = 16'h1234;
      @(negedge clk);
      check("usb_path", joystick_1, 16'h1234);
      joy_usb_2 = '0;
      @(negedge clk);
      check("usb_clear", joystick_1, 16'h0000);

      joy_db15_1 = 16'h0010;
      wait_j(0, 16'h0010, 25, n);
      check_rng("deb_press_lat", n, 15, 19);
      joy_db15_1 = 16'h0000;
      wait_j(0, 16'h0000, 25, n);
      check_rng("deb_release_lat", n, 15, 19);

      joy_db15_1 = 16'h0001;
      repeat (8) @(negedge clk);
      joy_db15_1 = 16'h0000;
      hits = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (joystick_0 !== 16'h0000) hits++;
      end
      check("glitch_reject", hits, 0);

      joy_db15_2 = 16'hFFFF;
      repeat (40) @(negedge clk);
      check("stuck_valid", db15_valid, 2'b01);
      check("stuck_j1", joystick_1, 16'h0000);
      joy_db15_2 = 16'h0000;
      n = 0;
      while (n < 7 && db15_valid !== 2'b11) begin
         @(negedge clk);
         n++;
      end
      check("stuck_recover", db15_valid, 2'b11);
      repeat (40) @(negedge clk);
      check("stuck_j1_settle", joystick_1, 16'h0000);

      joy_usb_1  = 16'h0400;
      joy_db15_2 = 16'h0001;
      swap       = 1'b1;
      wait_j(0, 16'h0401, 25, n);
      check_rng("swap_merge_lat", n, 1, 25);
      check("swap_j1", joystick_1, 16'h0000);
      db15_en = 1'b0;
      @(negedge clk);
      check("en_off", joystick_0, 16'h0400);
      db15_en = 1'b1;
      @(negedge clk);
      check("en_on", joystick_0, 16'h0401);
      swap = 1'b0;
      @(negedge clk);
      check("unswap_j0", joystick_0, 16'h0400);
      check("unswap_j1", joystick_1, 16'h0001);
      joy_usb_1  = '0;
      joy_db15_2 = '0;
      wait_j(1, 16'h0000, 25, n);
      check_rng("merge_clear", n, 1, 25);

      reset = 1'b1;
      @(negedge clk);
      reset      = 1'b0;
      joy_db15_1 = 16'h0008;
      joy_usb_1  = 16'h0100;
      repeat (9) @(negedge clk);
      check("mid_deb_pre", joystick_0, 16'h0100);
      reset = 1'b1;
      @(negedge clk);
      check("mid_rst_j0", joystick_0, 16'h0000);
      check("mid_rst_j1", joystick_1, 16'h0000);
      check("mid_rst_valid", db15_valid, 2'b11);
      reset     = 1'b0;
      joy_usb_1 = '0;
      wait_j(0, 16'h0008, 30, n);
      check("mid_rst_restart", n, 17);

      joy_db15_1 = '0;
      wait_j(0, 16'h0000, 25, n);
      check_rng("af_prep", n, 1, 25);
      joy_db15_1 = 16'h0020;
      wait_j(0, 16'h0030, 25, n);
`ifdef JOY_DB15_COND_AUTOFIRE_EN
      check_rng("af_start", n, 15, 19);
      begin
         int hi_len;
         int lo_len;
         int drops;
         hi_len = 0;
         lo_len = 0;
         drops  = 0;
         while (hi_len < 20 && joystick_0[4] === 1'b1) begin
            @(negedge clk);
            hi_len++;
            if (joystick_0[5] !== 1'b1) drops++;
         end
         while (lo_len < 20 && joystick_0[4] === 1'b0) begin
            @(negedge clk);
            lo_len++;
            if (joystick_0[5] !== 1'b1) drops++;
         end
         check("af_high_len", hi_len, 8);
         check("af_low_len", lo_len, 8);
         check("af_b_held", drops, 0);
      end
`else
      check("af_absent", n, -1);
      hits = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (joystick_0 !== 16'h0020) hits++;
      end
      check("b_passthru", hits, 0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
